fpu_arbiter: RTL and testbench

Shares one FPU add/sub unit between two requesters. The unit uses the team float format: sign [31], exponent [30:25], mantissa [24:0], bias 31. The arbiter accepts operand pairs over valid/ready, grants requesters round-robin, and issues a one-cycle start to the FPU core. It then waits for done, or times out, and returns result plus status to the granted requester over a valid/ready response channel. It sits between the requesting datapaths and the FPU core, which is wrapped with a start/done interface.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 17 +
 rtl/fpu_arbiter.sv | 122 ++++++++++++
 tb/tb_fpu_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU arbiter slice.
// Float format: sign [31], exponent [30:25], mantissa [24:0].
package fpu_pkg;

    localparam int BIAS   = 31;
    localparam int EXP_W  = 6;
    localparam int MANT_W = 25;

    localparam logic [3:0] ST_EXACT   = 4'b0001;
    localparam logic [3:0] ST_OVF     = 4'b0011;
    localparam logic [3:0] ST_UNF     = 4'b0111;
    localparam logic [3:0] ST_INEXACT = 4'b1111;
    localparam logic [3:0] ST_TIMEOUT = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick.
// On contention the requester not granted last time wins.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic any
);

    // a lone requester wins; on a tie, alternate away from last_grant
    always_comb begin
        any   = valid0 | valid1;
        grant = (valid0 & valid1) ? ~last_grant : valid1;
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one FPU add/sub core between two requesters.
// Round-robin accept, start pulse, done/timeout wait, response.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_op_a,
    input  logic [31:0]      req0_op_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_op_a,
    input  logic [31:0]      req1_op_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp_data,
    output logic [3:0]       rsp_status,
    output logic             fpu_start,
    output logic [31:0]      fpu_op_a,
    output logic [31:0]      fpu_op_b,
    input  logic             fpu_done,
    input  logic [31:0]      fpu_result,
    input  logic [3:0]       fpu_status,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    arb_state_t state;
    logic       last_grant;
    logic       grant_id;
    logic       grant;
    logic       any;
    logic       rsp_hs;
    logic [7:0] tmo_cnt;

    rr_arb2 u_rr (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .any        (any)
    );

    // ready only to the current winner while idle
    always_comb begin
        req0_ready = (state == IDLE) && any && (grant == 1'b0);
        req1_ready = (state == IDLE) && any && (grant == 1'b1);
        rsp_hs     = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
    end

    // arbiter FSM with registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            tmo_cnt    <= '0;
            fpu_start  <= 1'b0;
            fpu_op_a   <= '0;
            fpu_op_b   <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= '0;
            busy       <= 1'b0;
            op_count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any) begin
                        fpu_op_a  <= grant ? req1_op_a : req0_op_a;
                        fpu_op_b  <= grant ? req1_op_b : req0_op_b;
                        grant_id  <= grant;
                        fpu_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    fpu_start <= 1'b0;
                    tmo_cnt   <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (fpu_done) begin
                        rsp_data   <= fpu_result;
                        rsp_status <= fpu_status;
                        rsp0_valid <= ~grant_id;
                        rsp1_valid <= grant_id;
                        state      <= RESP;
                    end else if (tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data   <= '0;
                        rsp_status <= ST_TIMEOUT;
                        rsp0_valid <= ~grant_id;
                        rsp1_valid <= grant_id;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        last_grant <= grant_id;
                        op_count   <= op_count + 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a delay-programmable FPU stub.
// Contention runs from a table; corner cases are hand sequences.
module tb_fpu_arbiter;

    localparam int TMO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_op_a, req0_op_b, req1_op_a, req1_op_b;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_status;
    logic        fpu_start, fpu_done;
    logic [31:0] fpu_op_a, fpu_op_b, fpu_result;
    logic [3:0]  fpu_status;
    logic        busy;
    logic [15:0] op_count;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;

    logic        stub_en = 1'b0;
    int          stub_delay = 4;
    int          stub_cnt = 0;
    logic        stub_hit = 1'b0;
    logic        late_done = 1'b0;
    logic [31:0] stub_result = '0;
    logic [3:0]  stub_status = '0;

    assign fpu_done   = stub_hit | late_done;
    assign fpu_result = stub_result;
    assign fpu_status = stub_status;

    fpu_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op_a  (req0_op_a),
        .req0_op_b  (req0_op_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op_a  (req1_op_a),
        .req1_op_b  (req1_op_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .fpu_start  (fpu_start),
        .fpu_op_a   (fpu_op_a),
        .fpu_op_b   (fpu_op_b),
        .fpu_done   (fpu_done),
        .fpu_result (fpu_result),
        .fpu_status (fpu_status),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clock = ~clock;

    // FPU stub: one-cycle done stub_delay cycles after the start cycle
    always @(posedge clock) begin
        #1;
        if (fpu_start) begin
            stub_cnt = stub_delay;
            stub_hit = 1'b0;
        end else if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            stub_hit = stub_en && (stub_cnt == 0);
        end else begin
            stub_hit = 1'b0;
        end
    end

    always @(posedge clock) begin
        if (fpu_start) start_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic rv(input int id);
        return (id == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    task automatic wait_start(input string name);
        int n = 0;
        while (!fpu_start && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_start_seen"}, 32'(fpu_start), 32'd1);
    endtask

    // counts cycles from the start cycle to rsp valid; tracks op_a stability
    task automatic wait_rsp(input int id, input string name, output int n);
        logic [31:0] a0;
        int          unstable;
        a0 = fpu_op_a;
        unstable = 0;
        n = 0;
        while (!rv(id) && n < TMO + 10) begin
            tick();
            n++;
            if (fpu_op_a !== a0) unstable++;
        end
        chk({name, "_rsp_seen"}, 32'(rv(id)), 32'd1);
        chk({name, "_op_a_stable"}, unstable, 0);
    endtask

    typedef struct {
        int          gid;
        logic [31:0] res;
        logic [3:0]  st;
    } vec_t;

    vec_t tbl[4];
    int   n;
    logic [31:0] hd;
    logic [3:0]  hs;

    initial begin
        tbl[0] = '{0, 32'h40000000, 4'b0001};
        tbl[1] = '{1, 32'h41100000, 4'b1111};
        tbl[2] = '{0, 32'h3C800000, 4'b0111};
        tbl[3] = '{1, 32'h7FFFFFFF, 4'b0011};

        reset = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_op_a = '0; req0_op_b = '0;
        req1_op_a = '0; req1_op_b = '0;
        rsp0_ready = 0; rsp1_ready = 0;

        // reset state
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(fpu_start), 0);
        chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("rst_op_count", 32'(op_count), 0);
        chk("rst_op_a", fpu_op_a, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_ready", {req1_ready, req0_ready}, 0);
        reset = 1'b1;
        tick();

        // single request from requester 0
        stub_en = 1; stub_delay = 4;
        stub_result = 32'h40000000; stub_status = 4'b0001;
        req0_op_a = 32'h3E000000; req0_op_b = 32'h3E000000;
        req0_valid = 1;
        #0;
        chk("single_req0_ready", 32'(req0_ready), 1);
        chk("single_req1_ready", 32'(req1_ready), 0);
        wait_start("single");
        req0_valid = 0;
        chk("single_op_a", fpu_op_a, 32'h3E000000);
        chk("single_op_b", fpu_op_b, 32'h3E000000);
        wait_rsp(0, "single", n);
        chk("single_latency", n, 5);
        chk("single_data", rsp_data, 32'h40000000);
        chk("single_status", 32'(rsp_status), 32'b0001);
        chk("single_rsp1", 32'(rsp1_valid), 0);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        chk("single_op_count", 32'(op_count), 1);
        chk("single_starts", start_cnt, 1);
        chk("single_idle", 32'(busy), 0);

        // fresh reset so contention starts from requester 0
        reset = 0;
        tick();
        reset = 1;
        tick();

        // contention: both valid, responses accepted at once
        req0_op_a = 32'hA0A0A0A0; req0_op_b = 32'h0000000A;
        req1_op_a = 32'hB1B1B1B1; req1_op_b = 32'h0000000B;
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 4; i++) begin
            stub_result = tbl[i].res;
            stub_status = tbl[i].st;
            wait_start($sformatf("cont%0d", i));
            chk($sformatf("cont%0d_grant_op_a", i), fpu_op_a,
                tbl[i].gid ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
            wait_rsp(tbl[i].gid, $sformatf("cont%0d", i), n);
            chk($sformatf("cont%0d_other_rsp", i),
                32'(rv(1 - tbl[i].gid)), 0);
            chk($sformatf("cont%0d_data", i), rsp_data, tbl[i].res);
            chk($sformatf("cont%0d_status", i), 32'(rsp_status),
                32'(tbl[i].st));
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        tick();
        chk("cont_op_count", 32'(op_count), 4);

        // backpressure on requester 1
        stub_result = 32'h5A5A5A5A; stub_status = 4'b1111;
        req1_valid = 1;
        wait_start("bp");
        req1_valid = 0;
        req0_valid = 1;
        wait_rsp(1, "bp", n);
        hd = rsp_data;
        hs = rsp_status;
        chk("bp_data", hd, 32'h5A5A5A5A);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("bp%0d_valid", c), 32'(rsp1_valid), 1);
            chk($sformatf("bp%0d_data", c), rsp_data, hd);
            chk($sformatf("bp%0d_status", c), 32'(rsp_status), 32'(hs));
            chk($sformatf("bp%0d_req0_ready", c), 32'(req0_ready), 0);
            chk($sformatf("bp%0d_start", c), 32'(fpu_start), 0);
        end
        req0_valid = 0;
        rsp1_ready = 1;
        tick();
        rsp1_ready = 0;
        chk("bp_op_count", 32'(op_count), 5);
        chk("bp_rsp0", 32'(rsp0_valid), 0);

        // timeout: stub never answers
        stub_en = 0;
        req0_valid = 1;
        wait_start("tmo");
        req0_valid = 0;
        wait_rsp(0, "tmo", n);
        chk("tmo_latency", n, TMO + 1);
        chk("tmo_data", rsp_data, 0);
        chk("tmo_status", 32'(rsp_status), 32'b1000);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        chk("tmo_op_count", 32'(op_count), 6);
        late_done = 1;
        tick();
        late_done = 0;
        tick();
        chk("late_done_busy", 32'(busy), 0);
        chk("late_done_rsp", {rsp1_valid, rsp0_valid}, 0);
        chk("late_done_count", 32'(op_count), 6);

        // done arriving in the last timeout cycle wins
        stub_en = 1; stub_delay = TMO;
        stub_result = 32'h12345678; stub_status = 4'b0011;
        req1_valid = 1;
        wait_start("coll");
        req1_valid = 0;
        wait_rsp(1, "coll", n);
        chk("coll_latency", n, TMO + 1);
        chk("coll_status", 32'(rsp_status), 32'b0011);
        chk("coll_data", rsp_data, 32'h12345678);
        rsp1_ready = 1;
        tick();
        rsp1_ready = 0;
        chk("coll_op_count", 32'(op_count), 7);

        // asynchronous reset in the middle of WAIT
        stub_en = 1; stub_delay = 6;
        req1_valid = 1;
        wait_start("mid");
        req1_valid = 0;
        tick();
        tick();
        chk("mid_busy_before", 32'(busy), 1);
        #2;
        reset = 0;
        #1;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_rsp", {rsp1_valid, rsp0_valid}, 0);
        chk("mid_start", 32'(fpu_start), 0);
        chk("mid_op_a", fpu_op_a, 0);
        chk("mid_op_count", 32'(op_count), 0);
        tick();
        reset = 1;
        for (int c = 0; c < 8; c++) tick();
        chk("mid_no_rsp", {rsp1_valid, rsp0_valid}, 0);
        chk("mid_still_idle", 32'(busy), 0);
        req0_valid = 1; req1_valid = 1;
        #0;
        chk("mid_req0_wins", 32'(req0_ready), 1);
        chk("mid_req1_waits", 32'(req1_ready), 0);
        req0_valid = 0; req1_valid = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
